paraleloserie_com: RTL
======================

# paraleloserie_com

Transmit-side parallel-to-serial stage of the PCIe physical-layer path, directly upstream of the serial-to-parallel IDL/COM receiver. It accepts bytes through a valid/ready handshake and shifts them out MSB first, one bit per `clk32f` cycle. After reset it sends a training burst of COM symbols so the receiver can align. It then fills empty byte slots with IDL and inserts a COM every `COM_PERIOD` byte slots to keep the receiver locked.

## Interface
- `WIDTH`, 8, symbol width in bits; fixed at 8 for this release.
- `COM`, 8'hBC, alignment symbol (K28.5 byte value).
- `IDL`, 8'h7C, idle fill symbol.
- `MIN_COM`, 4, number of COM symbols sent after reset before data is accepted; must be at least 1.
- `COM_PERIOD`, 16, in ACTIVE every `COM_PERIOD`-th byte slot is a forced COM; 0 disables insertion; otherwise must be at least 2.
- `clk32f`  in  1  bit clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  byte to transmit; sampled only at a transfer.
- `valid_in`  in  1  `data_in` is valid.
- `ready`  out  1  combinational; the block accepts a byte at the next edge.
- `out`  out  1  serial line, equal to `shift[7]`.
- `valido`  out  1  high while the byte currently being shifted is user data.
- `active`  out  1  high in the ACTIVE state.

## Operation
- **State machine.**
  - States are SYNC (reset state) and ACTIVE.
  - SYNC goes to ACTIVE at the first byte boundary where `com_sent == MIN_COM`.
  - ACTIVE leaves only on `reset`.
- **Bit timing.**
  - `bitcnt` is a 3-bit counter and wraps 7→0.
  - A byte boundary is a rising edge with `bitcnt == 7`. At a boundary `shift` loads the next byte and `bitcnt` goes to 0.
  - At any other edge `shift` shifts left by one, zero fill, and `bitcnt` increments.
- **Reset values (asynchronous).**
  - `shift = COM`, `bitcnt = 0`, state SYNC, `com_sent = 1` (the preloaded COM counts), `byte_cnt = 0`, `valido = 0`.
  - Resulting outputs: `out = 1`, `ready = 0`, `active = 0`.
- **SYNC boundary with `com_sent < MIN_COM`.** Load COM, increment `com_sent`, `valido = 0`.
- **ACTIVE boundary, or the SYNC boundary that enters ACTIVE.**
  - If `COM_PERIOD != 0` and `byte_cnt == COM_PERIOD-1`: load COM, set `byte_cnt = 0`, `valido = 0`, and `ready` is low in that cycle.
  - Otherwise, if `valid_in && ready`: load `data_in`, set `valido = 1`, increment `byte_cnt`.
  - Otherwise: load IDL, set `valido = 0`, increment `byte_cnt`.
  - `byte_cnt` is 0 on entry to ACTIVE.
- **`ready` equation.** `ready = (bitcnt == 7) && (state == ACTIVE || com_sent == MIN_COM) && !com_insert`.
- **Handshake.**
  - A transfer occurs only on an edge where `valid_in && ready`.
  - `valid_in` without `ready` is ignored, not latched. Upstream holds `data_in` and `valid_in` until a transfer occurs.
  - No byte is ever dropped or duplicated.
- **Reset mid-byte.** The byte in flight is discarded, the SYNC burst restarts, and any data not yet transferred must be re-presented by upstream.

## Timing
- Cycle n is the n-th cycle after reset release; cycle 0 starts at release. `out` in cycle n shows bit `n mod 8` (MSB first) of the current byte.
- The SYNC burst occupies cycles 0 to 8·MIN_COM−1 (0–31 with defaults).
- The first `ready` pulse is in cycle 8·MIN_COM−1 (31). `active` rises at the edge ending cycle 31.
- Latency: a byte transferred at the edge ending cycle k drives its MSB on `out` in cycle k+1 and its LSB in cycle k+8. `valido` is high in exactly those 8 cycles.
- `ready` is high for at most one cycle in every 8.
- Throughput with defaults: 15 data bytes per 16 slots. With `COM_PERIOD = 0` it is one byte per 8 cycles.

## Structure
- A shared package holds:
  - COM and IDL constants;
  - the state enum {SYNC, ACTIVE};
  - a `WIDTH` constant reused by the receiver.
- One sub-module, `ps_shift8`: the 8-bit load/shift register and 3-bit bit counter, with a `boundary` output.
- The top level holds the FSM, `com_sent`, `byte_cnt`, and the `ready`/`valido` logic.

## Test plan
- **Reset burst.** Reset, then release with `valid_in = 0` → `out` carries 10111100 ×4 in cycles 0–31; `ready` is high only in cycle 31; afterwards the line carries IDL (01111100) repeatedly.
- **Back-to-back data.** Hold `valid_in = 1` with `data_in` = 8'hA5 then 8'h3C, advancing on each transfer → 10100101 in cycles 32–39 and 00111100 in cycles 40–47, with `valido` high in cycles 32–47.
- **COM insertion.** Default `COM_PERIOD`, `valid_in` held high → the 16th ACTIVE slot (cycles 152–159) carries COM, `ready` is low in cycle 151, `data_in` is held, and the held byte goes out in cycles 160–167.
- **Valid gap.** Deassert `valid_in` for one boundary → exactly one IDL byte with `valido = 0`, then data resumes with no loss or duplication.
- **Mid-byte reset.** Assert `reset` in cycle 43 (mid-byte) → `out = 1`, `active = 0` and `ready = 0` immediately; after release the full burst of 4 COMs repeats.
- **Loopback.** Connect `out` to the serial-to-parallel receiver → the received byte sequence equals the transmitted data sequence with COM/IDL slots stripped.

Source files
------------

// File: rtl/paraleloserie_com_pkg.sv
// Shared symbols and state type for the PCIe parallel/serial COM-IDL path.
package paraleloserie_com_pkg;

    localparam int WIDTH = 8;

    localparam logic [WIDTH-1:0] COM = 8'hBC;
    localparam logic [WIDTH-1:0] IDL = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } ps_state_e;

endpackage

// File: rtl/paraleloserie_com_if.sv
// Byte handshake plus serial line and status flags of the transmitter.
interface paraleloserie_com_if;

    logic [paraleloserie_com_pkg::WIDTH-1:0] data_in;
    logic                                    valid_in;
    logic                                    ready;
    logic                                    out;
    logic                                    valido;
    logic                                    active;

    modport master (
        output data_in, valid_in,
        input  ready, out, valido, active
    );

    modport slave (
        input  data_in, valid_in,
        output ready, out, valido, active
    );

endinterface

// File: rtl/ps_shift8.sv
// Byte load/shift register with its bit counter; boundary marks the last bit of a byte.
module ps_shift8
    import paraleloserie_com_pkg::*;
(
    input  logic             clk32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_byte,
    output logic             msb,
    output logic             boundary
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;

    assign boundary = (bitcnt_q == 3'd7);
    assign msb      = shift_q[WIDTH-1];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        shift_d  = {shift_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (boundary) begin
            shift_d = load_byte;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            shift_q  <= COM;
            bitcnt_q <= '0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: rtl/paraleloserie_com.sv
// Parallel-to-serial transmitter: COM training burst, then data with IDL fill and periodic COM.
module paraleloserie_com
    import paraleloserie_com_pkg::*;
#(
    parameter int MIN_COM    = 4,
    parameter int COM_PERIOD = 16
) (
    input  logic                clk32f,
    input  logic                reset,
    paraleloserie_com_if.slave  bus
);

    localparam int              CSW       = $clog2(MIN_COM + 1);
    localparam logic [CSW-1:0]  CS_MAX    = CSW'(MIN_COM);
    localparam int              BCW       = (COM_PERIOD > 2) ? $clog2(COM_PERIOD) : 1;
    localparam logic [BCW-1:0]  BC_LAST   = BCW'(COM_PERIOD - 1);
    localparam bit              INSERT_EN = (COM_PERIOD != 0);

    ps_state_e        state_q, state_d;
    logic [CSW-1:0]   com_sent_q, com_sent_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic             valido_q, valido_d;

    logic             boundary;
    logic             msb;
    logic [WIDTH-1:0] load_byte;
    logic             enter_active;
    logic             com_insert;

    ps_shift8 u_shift (
        .clk32f    (clk32f),
        .reset     (reset),
        .load_byte (load_byte),
        .msb       (msb),
        .boundary  (boundary)
    );

    // The boundary that completes the burst already behaves as an ACTIVE slot.
    assign enter_active = (state_q == ACTIVE) || (com_sent_q == CS_MAX);
    assign com_insert   = INSERT_EN && enter_active && (byte_cnt_q == BC_LAST);

    assign bus.ready  = boundary && enter_active && !com_insert;
    assign bus.out    = msb;
    assign bus.valido = valido_q;
    assign bus.active = (state_q == ACTIVE);

    always_comb begin
        state_d    = state_q;
        com_sent_d = com_sent_q;
        byte_cnt_d = byte_cnt_q;
        valido_d   = valido_q;
        load_byte  = COM;
        if (boundary) begin
            if (!enter_active) begin
                com_sent_d = com_sent_q + CSW'(1);
                valido_d   = 1'b0;
            end else begin
                state_d = ACTIVE;
                if (com_insert) begin
                    byte_cnt_d = '0;
                    valido_d   = 1'b0;
                end else if (bus.valid_in && bus.ready) begin
                    load_byte  = bus.data_in;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    valido_d   = 1'b1;
                end else begin
                    load_byte  = IDL;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    valido_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            com_sent_q <= CSW'(1);
            byte_cnt_q <= '0;
            valido_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            com_sent_q <= com_sent_d;
            byte_cnt_q <= byte_cnt_d;
            valido_q   <= valido_d;
        end
    end

endmodule
